// File: rtl/game_pkg.sv
// Shared types and seven-segment codes for the game-progress controller.
// Segment codes are active-low, bit 6 = A down to bit 0 = G.
package game_pkg;

  typedef enum logic [2:0] {
    ST_NEWGAME = 3'd0,
    ST_PLAY    = 3'd1,
    ST_DYING   = 3'd2,
    ST_WINNING = 3'd3,
    ST_OVER    = 3'd4,
    ST_VICTORY = 3'd5
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  function automatic logic [6:0] digit_code(input logic [3:0] value);
    case (value)
      4'd0:    digit_code = SEG_0;
      4'd1:    digit_code = SEG_1;
      4'd2:    digit_code = SEG_2;
      4'd3:    digit_code = SEG_3;
      4'd4:    digit_code = SEG_4;
      4'd5:    digit_code = SEG_5;
      4'd6:    digit_code = SEG_6;
      4'd7:    digit_code = SEG_7;
      4'd8:    digit_code = SEG_8;
      4'd9:    digit_code = SEG_9;
      default: digit_code = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// Combinational decimal-to-seven-segment decoder; values above 9 blank the digit.
module seg7_digit
  import game_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = digit_code(i_value);
  end

endmodule

// File: rtl/game_progress.sv
// Round/level/lives state machine with collision edge detection, a registered
// round reset for the frog and cars, and the lives/level seven-segment digits.
module game_progress
  import game_pkg::*;
#(
  parameter int NUM_LEVELS  = 8,
  parameter int START_LIVES = 3,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       death_collision,
  input  logic       win_collision,
  input  logic       restart,
  output logic       round_reset,
  output logic [3:0] level,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       game_won,
  output logic [6:0] o_Segment1,
  output logic [6:0] o_Segment2
);

  localparam int              CNT_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]      LEVEL_LAST = 4'(NUM_LEVELS - 1);
  localparam logic [1:0]      LIVES_INIT = 2'(START_LIVES);

  state_e           r_state, w_state_nxt;
  logic [3:0]       r_level, w_level_nxt;
  logic [1:0]       r_lives, w_lives_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic r_death_d, r_win_d, r_restart_d;
  logic w_death_edge, w_win_edge, w_restart_edge;
  logic w_hold_done;

  logic [3:0] w_level_disp;
  logic [6:0] w_lives_code, w_level_code, w_seg1_nxt;

  assign w_death_edge   = death_collision & ~r_death_d;
  assign w_win_edge     = win_collision   & ~r_win_d;
  assign w_restart_edge = restart         & ~r_restart_d;
  assign w_hold_done    = (r_cnt == CNT_LAST);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_lives_nxt = r_lives;
    w_cnt_nxt   = r_cnt;
    if (w_restart_edge) begin
      w_state_nxt = ST_NEWGAME;
      w_level_nxt = 4'd0;
      w_lives_nxt = LIVES_INIT;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        ST_NEWGAME: begin
          w_state_nxt = ST_PLAY;
          w_level_nxt = 4'd0;
          w_lives_nxt = LIVES_INIT;
          w_cnt_nxt   = '0;
        end
        ST_PLAY: begin
          // Death wins over a simultaneous goal touch.
          if (w_death_edge) begin
            w_state_nxt = ST_DYING;
            w_lives_nxt = r_lives - 2'd1;
          end else if (w_win_edge) begin
            w_state_nxt = ST_WINNING;
          end
        end
        ST_DYING: begin
          if (w_hold_done) begin
            w_cnt_nxt   = '0;
            w_state_nxt = (r_lives == 2'd0) ? ST_OVER : ST_PLAY;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_WINNING: begin
          if (w_hold_done) begin
            w_cnt_nxt = '0;
            if (r_level == LEVEL_LAST) begin
              w_state_nxt = ST_VICTORY;
            end else begin
              w_level_nxt = r_level + 4'd1;
              w_state_nxt = ST_PLAY;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_OVER, ST_VICTORY: w_state_nxt = r_state;
        default:             w_state_nxt = ST_NEWGAME;
      endcase
    end
  end

  assign w_level_disp = r_level + 4'd1;

  seg7_digit u_lives_digit (
    .i_value ({2'b00, r_lives}),
    .o_seg   (w_lives_code)
  );

  seg7_digit u_level_digit (
    .i_value (w_level_disp),
    .o_seg   (w_level_code)
  );

  always_comb begin
    case (r_state)
      ST_OVER:    w_seg1_nxt = SEG_DASH;
      ST_VICTORY: w_seg1_nxt = SEG_BLANK;
      default:    w_seg1_nxt = w_lives_code;
    endcase
  end

  // Outputs are registered from the current state, so they trail the state by one edge.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_NEWGAME;
      r_level     <= 4'd0;
      r_lives     <= LIVES_INIT;
      r_cnt       <= '0;
      r_death_d   <= 1'b0;
      r_win_d     <= 1'b0;
      r_restart_d <= 1'b0;
      round_reset <= 1'b1;
      level       <= 4'd0;
      lives       <= LIVES_INIT;
      game_over   <= 1'b0;
      game_won    <= 1'b0;
      o_Segment1  <= digit_code({2'b00, LIVES_INIT});
      o_Segment2  <= digit_code(4'd1);
    end else begin
      r_state     <= w_state_nxt;
      r_level     <= w_level_nxt;
      r_lives     <= w_lives_nxt;
      r_cnt       <= w_cnt_nxt;
      r_death_d   <= death_collision;
      r_win_d     <= win_collision;
      r_restart_d <= restart;
      round_reset <= (r_state != ST_PLAY);
      level       <= r_level;
      lives       <= r_lives;
      game_over   <= (r_state == ST_OVER);
      game_won    <= (r_state == ST_VICTORY);
      o_Segment1  <= w_seg1_nxt;
      o_Segment2  <= w_level_code;
    end
  end

endmodule

// File: tb/tb_game_progress.sv
// Table-driven bench for game_progress with HOLD_CYCLES=4, NUM_LEVELS=2, START_LIVES=2,
// plus a hand-written round-reset latency/width sequence.
module tb_game_progress;

  localparam logic [6:0] S_D0    = 7'b0000001;
  localparam logic [6:0] S_D1    = 7'b1001111;
  localparam logic [6:0] S_D2    = 7'b0010010;
  localparam logic [6:0] S_DASH  = 7'b1111110;
  localparam logic [6:0] S_BLANK = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset, death_collision, win_collision, restart;
  logic       round_reset, game_over, game_won;
  logic [3:0] level;
  logic [1:0] lives;
  logic [6:0] o_Segment1, o_Segment2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst, death, win, rstrt;
    logic       rr;
    logic [3:0] lvl;
    logic [1:0] lv;
    logic       over, won;
    logic [6:0] s1, s2;
  } vec_t;

  vec_t vecs[$];

  game_progress #(
    .NUM_LEVELS  (2),
    .START_LIVES (2),
    .HOLD_CYCLES (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .death_collision (death_collision),
    .win_collision   (win_collision),
    .restart         (restart),
    .round_reset     (round_reset),
    .level           (level),
    .lives           (lives),
    .game_over       (game_over),
    .game_won        (game_won),
    .o_Segment1      (o_Segment1),
    .o_Segment2      (o_Segment2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rs, input logic d, input logic w, input logic r,
                     input logic rr, input int lvl, input int lv,
                     input logic ov, input logic wn, input logic [6:0] s1, input logic [6:0] s2);
    vec_t v;
    v.rst = rs; v.death = d; v.win = w; v.rstrt = r;
    v.rr = rr; v.lvl = 4'(lvl); v.lv = 2'(lv); v.over = ov; v.won = wn;
    v.s1 = s1; v.s2 = s2;
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    reset = 1'b1; death_collision = 1'b0; win_collision = 1'b0; restart = 1'b0;

    // Reset for two cycles, release: round_reset high one more cycle.
    add(1,0,0,0, 1,0,2,0,0, S_D2, S_D1);
    add(1,0,0,0, 1,0,2,0,0, S_D2, S_D1);
    add(0,0,0,0, 1,0,2,0,0, S_D2, S_D1);
    add(0,0,0,0, 0,0,2,0,0, S_D2, S_D1);
    add(0,0,0,0, 0,0,2,0,0, S_D2, S_D1);
    // Death held ten cycles: one decrement, round_reset high four cycles.
    add(0,1,0,0, 0,0,2,0,0, S_D2, S_D1);
    for (int k = 0; k < 4; k++) add(0,1,0,0, 1,0,1,0,0, S_D1, S_D1);
    for (int k = 0; k < 5; k++) add(0,1,0,0, 0,0,1,0,0, S_D1, S_D1);
    add(0,0,0,0, 0,0,1,0,0, S_D1, S_D1);
    // Second death: lives 0, then OVER.
    add(0,1,0,0, 0,0,1,0,0, S_D1, S_D1);
    for (int k = 0; k < 4; k++) add(0,0,0,0, 1,0,0,0,0, S_D0, S_D1);
    add(0,0,0,0, 1,0,0,1,0, S_DASH, S_D1);
    add(0,0,0,0, 1,0,0,1,0, S_DASH, S_D1);
    // Restart from OVER.
    add(0,0,0,1, 1,0,0,1,0, S_DASH, S_D1);
    add(0,0,0,0, 1,0,2,0,0, S_D2, S_D1);
    add(0,0,0,0, 0,0,2,0,0, S_D2, S_D1);
    // Win: level 0 -> 1.
    add(0,0,1,0, 0,0,2,0,0, S_D2, S_D1);
    for (int k = 0; k < 4; k++) add(0,0,0,0, 1,0,2,0,0, S_D2, S_D1);
    add(0,0,0,0, 0,1,2,0,0, S_D2, S_D2);
    // Win on last level: VICTORY.
    add(0,0,1,0, 0,1,2,0,0, S_D2, S_D2);
    for (int k = 0; k < 4; k++) add(0,0,0,0, 1,1,2,0,0, S_D2, S_D2);
    add(0,0,0,0, 1,1,2,0,1, S_BLANK, S_D2);
    add(0,0,0,0, 1,1,2,0,1, S_BLANK, S_D2);
    add(0,0,0,1, 1,1,2,0,1, S_BLANK, S_D2);
    add(0,0,0,0, 1,0,2,0,0, S_D2, S_D1);
    add(0,0,0,0, 0,0,2,0,0, S_D2, S_D1);
    // Death and win together: death wins; later win edge in DYING ignored.
    add(0,1,1,0, 0,0,2,0,0, S_D2, S_D1);
    add(0,0,0,0, 1,0,1,0,0, S_D1, S_D1);
    add(0,0,1,0, 1,0,1,0,0, S_D1, S_D1);
    add(0,0,0,0, 1,0,1,0,0, S_D1, S_D1);
    add(0,0,0,0, 1,0,1,0,0, S_D1, S_D1);
    add(0,0,0,0, 0,0,1,0,0, S_D1, S_D1);
    add(0,0,0,0, 0,0,1,0,0, S_D1, S_D1);
    // Reset on the second WINNING cycle: no level increment.
    add(0,0,1,0, 0,0,1,0,0, S_D1, S_D1);
    add(0,0,0,0, 1,0,1,0,0, S_D1, S_D1);
    add(1,0,0,0, 1,0,2,0,0, S_D2, S_D1);
    add(0,0,0,0, 1,0,2,0,0, S_D2, S_D1);
    add(0,0,0,0, 0,0,2,0,0, S_D2, S_D1);
    add(0,0,0,0, 0,0,2,0,0, S_D2, S_D1);
    // Restart beats a simultaneous death edge.
    add(0,1,0,1, 0,0,2,0,0, S_D2, S_D1);
    add(0,0,0,0, 1,0,2,0,0, S_D2, S_D1);
    add(0,0,0,0, 0,0,2,0,0, S_D2, S_D1);

    foreach (vecs[i]) begin
      reset           = vecs[i].rst;
      death_collision = vecs[i].death;
      win_collision   = vecs[i].win;
      restart         = vecs[i].rstrt;
      tick();
      check($sformatf("vec%0d {rr,lvl,lives,over,won,seg1,seg2}", i),
            32'({round_reset, level, lives, game_over, game_won, o_Segment1, o_Segment2}),
            32'({vecs[i].rr, vecs[i].lvl, vecs[i].lv, vecs[i].over, vecs[i].won,
                 vecs[i].s1, vecs[i].s2}));
    end

    // Single-cycle death pulse: round_reset rises two cycles later, lasts four.
    death_collision = 1'b1;
    tick();
    death_collision = 1'b0;
    n = 1;
    while (!round_reset && n < 20) begin
      tick();
      n++;
    end
    check("round_reset rise latency", 32'(n), 32'd2);
    n = 0;
    while (round_reset && n < 20) begin
      tick();
      n++;
    end
    check("round_reset high width", 32'(n), 32'd4);
    check("lives after pulse death", 32'(lives), 32'd1);
    check("level after pulse death", 32'(level), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
